// File: rtl/me_pkg.sv
// me_pkg: shared constants and types for the motion-estimation sequencer.
// Holds search range, SAD latency, derived sizes, FSM states and the tag type.
package me_pkg;

    localparam int RANGE_X = 8;
    localparam int RANGE_Y = 16;
    localparam int SAD_LAT = 2;
    localparam int SW_W    = RANGE_X + 3;
    localparam int NCAND   = RANGE_X * RANGE_Y;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_TB = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] x;
        logic [3:0] y;
    } cand_t;

endpackage

// File: rtl/pa_sequencer_if.sv
// pa_sequencer_if: memory read ports plus SAD array drive/return bus.
// master = sequencer side, slave = memories and SAD array side.
interface pa_sequencer_if;

    logic        tb_rd;
    logic [5:0]  tb_addr;
    logic [31:0] tb_data;
    logic        sw_rd;
    logic [8:0]  sw_addr;
    logic [31:0] sw_data;
    logic        en_tb;
    logic [31:0] pel_tb;
    logic        en_sw;
    logic [31:0] pel_sw;
    logic [15:0] sad;

    modport master (
        output tb_rd, tb_addr, sw_rd, sw_addr,
        output en_tb, pel_tb, en_sw, pel_sw,
        input  tb_data, sw_data, sad
    );

    modport slave (
        input  tb_rd, tb_addr, sw_rd, sw_addr,
        input  en_tb, pel_tb, en_sw, pel_sw,
        output tb_data, sw_data, sad
    );

endinterface

// File: rtl/tag_delay.sv
// tag_delay: DEPTH-stage shift line carrying a candidate tag and its valid.
// Ports: clk, rst_n, vld/tag in, vld_dly/tag_dly out after DEPTH cycles.
module tag_delay
    import me_pkg::*;
#(
    parameter int DEPTH = SAD_LAT + 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  vld,
    input  cand_t tag,
    output logic  vld_dly,
    output cand_t tag_dly
);

    logic [DEPTH-1:0] v_sr;
    cand_t            t_sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                t_sr[i] <= '0;
            end
        end else begin
            v_sr[0] <= vld;
            t_sr[0] <= tag;
            for (int i = 1; i < DEPTH; i++) begin
                v_sr[i] <= v_sr[i-1];
                t_sr[i] <= t_sr[i-1];
            end
        end
    end

    assign vld_dly = v_sr[DEPTH-1];
    assign tag_dly = t_sr[DEPTH-1];

endmodule

// File: rtl/pa_sequencer.sv
// pa_sequencer: fetches template + search window, feeds the SAD array, keeps min.
// Ports: clk, rst_n, start, busy, done, best_sad/x/y, bus (memories + SAD array).
module pa_sequencer #(
    parameter int RANGE_X = me_pkg::RANGE_X,
    parameter int RANGE_Y = me_pkg::RANGE_Y,
    parameter int SAD_LAT = me_pkg::SAD_LAT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [15:0]    best_sad,
    output logic [2:0]     best_x,
    output logic [3:0]     best_y,
    pa_sequencer_if.master bus
);

    localparam int         SW_WORDS = RANGE_X + 3;
    localparam logic [2:0] X_LAST   = 3'(RANGE_X - 1);
    localparam logic [3:0] Y_LAST   = 4'(RANGE_Y - 1);
    localparam logic [5:0] D_LAST   = 6'(SAD_LAT + 1);

    me_pkg::state_t state;
    me_pkg::state_t state_nx;

    logic [5:0]    w;
    logic [2:0]    cx;
    logic [3:0]    cy;
    logic          w_last;
    logic          cand_last;
    logic          drain_last;
    logic          tb_rd;
    logic          sw_rd;
    logic          en_tb;
    logic          en_sw;
    logic [8:0]    lin;
    logic          tag_vld;
    logic          tag_vld_dly;
    me_pkg::cand_t tag;
    me_pkg::cand_t tag_dly;

    assign w_last     = (w == 6'd63);
    assign cand_last  = (cx == X_LAST) && (cy == Y_LAST);
    assign drain_last = (w == D_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= me_pkg::S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            me_pkg::S_IDLE:
                if (start) state_nx = me_pkg::S_LOAD_TB;
            me_pkg::S_LOAD_TB:
                if (w_last) state_nx = me_pkg::S_RUN;
            me_pkg::S_RUN:
                if (w_last && cand_last) state_nx = me_pkg::S_DRAIN;
            me_pkg::S_DRAIN:
                if (drain_last) state_nx = me_pkg::S_DONE;
            me_pkg::S_DONE:
                state_nx = me_pkg::S_IDLE;
            default:
                state_nx = me_pkg::S_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b1;
        done  = 1'b0;
        tb_rd = 1'b0;
        sw_rd = 1'b0;
        unique case (1'b1)
            (state == me_pkg::S_IDLE):    busy  = 1'b0;
            (state == me_pkg::S_LOAD_TB): tb_rd = 1'b1;
            (state == me_pkg::S_RUN):     sw_rd = 1'b1;
            (state == me_pkg::S_DONE):    done  = 1'b1;
            default: ;
        endcase
    end

    // w is the word index (r = w[5:2], c = w[1:0]) in LOAD_TB/RUN
    // and the cycle count in DRAIN; it restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w  <= '0;
            cx <= '0;
            cy <= '0;
        end else begin
            if (state_nx != state) begin
                w <= '0;
            end else begin
                w <= w + 6'd1;
            end
            if (state == me_pkg::S_IDLE) begin
                cx <= '0;
                cy <= '0;
            end else if (state == me_pkg::S_RUN && w_last) begin
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= cy + 4'd1;
                end else begin
                    cx <= cx + 3'd1;
                end
            end
        end
    end

    always_comb begin
        lin = ({5'd0, cy} + {5'd0, w[5:2]}) * 9'(SW_WORDS)
            + {6'd0, cx} + {7'd0, w[1:0]};
    end

    assign bus.tb_rd   = tb_rd;
    assign bus.sw_rd   = sw_rd;
    assign bus.tb_addr = tb_rd ? w : '0;
    assign bus.sw_addr = sw_rd ? lin : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_tb <= 1'b0;
            en_sw <= 1'b0;
        end else begin
            en_tb <= tb_rd;
            en_sw <= sw_rd;
        end
    end

    assign bus.en_tb  = en_tb;
    assign bus.en_sw  = en_sw;
    assign bus.pel_tb = en_tb ? bus.tb_data : '0;
    assign bus.pel_sw = en_sw ? bus.sw_data : '0;

    // The tag leaves with the candidate's last read; one stage covers
    // the read-to-en_sw register, the rest the array latency.
    assign tag_vld = sw_rd && w_last;
    assign tag     = {cx, cy};

    tag_delay #(
        .DEPTH (SAD_LAT + 1)
    ) u_tag_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (tag_vld),
        .tag     (tag),
        .vld_dly (tag_vld_dly),
        .tag_dly (tag_dly)
    );

    // Strict less-than keeps the earliest candidate on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad <= '0;
            best_x   <= '0;
            best_y   <= '0;
        end else if (state == me_pkg::S_IDLE && start) begin
            best_sad <= 16'hFFFF;
            best_x   <= '0;
            best_y   <= '0;
        end else if (tag_vld_dly && (bus.sad < best_sad)) begin
            best_sad <= bus.sad;
            best_x   <= tag_dly.x;
            best_y   <= tag_dly.y;
        end
    end

endmodule

// File: tb/tb_pa_sequencer.sv
// tb_pa_sequencer: models both memories and the SAD array around pa_sequencer.
// Expected best_* results are queued at start and compared at done.
module tb_pa_sequencer;
    import me_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] best_sad;
    logic [2:0]  best_x;
    logic [3:0]  best_y;

    pa_sequencer_if bus ();

    pa_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .best_sad (best_sad),
        .best_x   (best_x),
        .best_y   (best_y),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int x;
        int y;
    } res_t;

    res_t        exp_q [$];
    int          due_q [$];
    logic [15:0] val_q [$];

    int n_vec = 0;
    int n_bad = 0;
    int mode  = 0;
    int cyc   = 0;
    int ltb   = 0;
    int nsw   = 0;
    int run   = 0;
    int run_last = 0;

    logic       tb_rd_p   = 1'b0;
    logic       sw_rd_p   = 1'b0;
    logic [5:0] tb_addr_p = '0;
    logic [8:0] sw_addr_p = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tpat(input logic [5:0] a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    function automatic logic [31:0] spat(input logic [8:0] a);
        return 32'h5A00_0000 | 32'(a);
    endfunction

    function automatic logic [15:0] sad_of(input int k);
        int x;
        int y;
        x = k % RANGE_X;
        y = k / RANGE_X;
        if (mode == 1) return 16'd0;
        return (x == 5 && y == 9) ? 16'd100 : 16'd200;
    endfunction

    // Monitor: checks strobes, addresses and pixel gating every busy cycle
    // and schedules each candidate's sad SAD_LAT cycles after its last en_sw.
    always @(negedge clk) begin
        int k;
        int r;
        int c;
        cyc++;
        if (!rst_n) begin
            due_q.delete();
            val_q.delete();
            run = 0;
        end
        if (!busy) begin
            ltb = 0;
            nsw = 0;
        end
        if (rst_n && busy) begin
            check("en_tb", 32'(bus.en_tb), 32'(tb_rd_p));
            check("pel_tb", bus.pel_tb, tb_rd_p ? tpat(tb_addr_p) : 0);
            check("en_sw", 32'(bus.en_sw), 32'(sw_rd_p));
            check("pel_sw", bus.pel_sw, sw_rd_p ? spat(sw_addr_p) : 0);
            if (bus.tb_rd) begin
                check("tb_addr", 32'(bus.tb_addr), ltb);
                ltb++;
            end else begin
                check("tb_addr_idle", 32'(bus.tb_addr), 0);
            end
            if (bus.sw_rd) begin
                k = nsw / 64;
                r = (nsw % 64) / 4;
                c = nsw % 4;
                check("sw_addr", 32'(bus.sw_addr),
                      (k / RANGE_X + r) * SW_W + k % RANGE_X + c);
                if (nsw == (3 * RANGE_X + 2) * 64)
                    check("probe_2_3", 32'(bus.sw_addr), 35);
                if (nsw == NCAND * 64 - 1)
                    check("probe_7_15", 32'(bus.sw_addr), 340);
                nsw++;
            end else begin
                check("sw_addr_idle", 32'(bus.sw_addr), 0);
            end
        end
        if (bus.en_sw) begin
            run++;
            if (run % 64 == 0) begin
                due_q.push_back(cyc + SAD_LAT);
                val_q.push_back(sad_of(run / 64 - 1));
            end
        end else if (run > 0) begin
            run_last = run;
            run = 0;
        end
        tb_rd_p   = bus.tb_rd;
        sw_rd_p   = bus.sw_rd;
        tb_addr_p = bus.tb_addr;
        sw_addr_p = bus.sw_addr;
    end

    // Memories answer one cycle after the read; sad outside a sample
    // slot is 0 so a mistimed sample shows up as a wrong minimum.
    always @(posedge clk) begin
        #1;
        bus.tb_data = tb_rd_p ? tpat(tb_addr_p) : 32'hDEAD_BEEF;
        bus.sw_data = sw_rd_p ? spat(sw_addr_p) : 32'hDEAD_BEEF;
        if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
            bus.sad = val_q[0];
            void'(due_q.pop_front());
            void'(val_q.pop_front());
        end else begin
            bus.sad = 16'd0;
        end
    end

    task automatic check_idle(input string p);
        check({p, "_busy"}, 32'(busy), 0);
        check({p, "_done"}, 32'(done), 0);
        check({p, "_tb_rd"}, 32'(bus.tb_rd), 0);
        check({p, "_tb_addr"}, 32'(bus.tb_addr), 0);
        check({p, "_sw_rd"}, 32'(bus.sw_rd), 0);
        check({p, "_sw_addr"}, 32'(bus.sw_addr), 0);
        check({p, "_en_tb"}, 32'(bus.en_tb), 0);
        check({p, "_pel_tb"}, bus.pel_tb, 0);
        check({p, "_en_sw"}, 32'(bus.en_sw), 0);
        check({p, "_pel_sw"}, bus.pel_sw, 0);
        check({p, "_best_sad"}, 32'(best_sad), 0);
        check({p, "_best_x"}, 32'(best_x), 0);
        check({p, "_best_y"}, 32'(best_y), 0);
    endtask

    // m: 0 = single minimum at (5,9), 1 = all zero.
    // poke: cycle at which a stray start is pulsed (0 = none).
    // abort: pull rst_n low at RUN cycle 1000.
    task automatic do_run(input int m, input int poke, input bit abort);
        int   n;
        bit   seen;
        res_t e;
        mode  = m;
        start = 1'b1;
        if (!abort) begin
            e.s = (m == 0) ? 100 : 0;
            e.x = (m == 0) ? 5 : 0;
            e.y = (m == 0) ? 9 : 0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check("busy_on", 32'(busy), 1);
        check("best_init", 32'(best_sad), 32'hFFFF);
        seen = 1'b0;
        while (n < 9000) begin
            if (abort && n == 65 + 1000) begin
                check("abort_in_run", 32'(bus.sw_rd), 1);
                rst_n = 1'b0;
                #1;
                check_idle("abort");
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                check("post_rst_busy", 32'(busy), 0);
                check("post_rst_best", 32'(best_sad), 0);
                return;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (poke != 0 && n == poke);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!seen) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("done_lat", n, 1 + 64 + 8192 + SAD_LAT + 2);
        check("en_sw_run", run_last, 8192);
        check("done_busy", 32'(busy), 1);
        check("best_sad", 32'(best_sad), e.s);
        check("best_x", 32'(best_x), e.x);
        check("best_y", 32'(best_y), e.y);
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        check("hold_sad", 32'(best_sad), e.s);
        check("hold_x", 32'(best_x), e.x);
        check("hold_y", 32'(best_y), e.y);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        bus.tb_data = '0;
        bus.sw_data = '0;
        bus.sad     = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_run(0, 0, 1'b0);
        do_run(1, 500, 1'b0);
        do_run(0, 0, 1'b1);
        do_run(0, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
